// File: rtl/moravec_corner_collector.sv
// Thresholds the raster-order Moravec response stream, converts accepted pixels to (x,y) and
// buffers them in a FWFT FIFO. Define MORAVEC_BORDER_SKIP_EN to exclude the one-pixel image border.
module moravec_corner_collector #(
    parameter int N         = 8,
    parameter int respWidth = 16,
    parameter int DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [respWidth-1:0]        threshold,
    input  logic                        resp_valid,
    input  logic [respWidth-1:0]        resp_value,
    input  logic                        resp_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(N)-1:0]        out_x,
    output logic [$clog2(N)-1:0]        out_y,
    output logic [respWidth-1:0]        out_score,
    output logic [$clog2(N*N):0]        corner_count,
    output logic                        frame_done,
    output logic                        overflow
);
    localparam int bitSize    = $clog2(N*N);
    localparam int coordWidth = $clog2(N);
    localparam int AW         = $clog2(DEPTH);
    localparam int PIX        = N*N;

    typedef struct packed {
        logic [coordWidth-1:0] x;
        logic [coordWidth-1:0] y;
        logic [respWidth-1:0]  score;
    } entry_t;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [bitSize-1:0]    idx;
    logic [coordWidth-1:0] cur_x, cur_y;
    logic                  border, in_frame, frame_end, last_pix, cand, push, pop, full;
    entry_t                mem [DEPTH];
    entry_t                head;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;

    assign cur_x    = coordWidth'(int'(idx) % N);
    assign cur_y    = coordWidth'(int'(idx) / N);
    assign last_pix = (idx == bitSize'(PIX-1));

`ifdef MORAVEC_BORDER_SKIP_EN
    // The 3x3 window is incomplete on the outermost ring, so those responses are meaningless.
    assign border = (cur_x == '0) || (cur_x == coordWidth'(N-1)) ||
                    (cur_y == '0) || (cur_y == coordWidth'(N-1));
`else
    assign border = 1'b0;
`endif

    assign in_frame  = resp_valid && (state != DRAIN);
    assign frame_end = in_frame && (resp_last || last_pix);
    assign cand      = in_frame && (resp_value > threshold) && !border;
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = cand && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (resp_valid) state_nxt = frame_end ? DRAIN : COLLECT;
            COLLECT: if (frame_end) state_nxt = DRAIN;
            DRAIN: begin
                if (count == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            corner_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (in_frame) idx <= frame_end ? '0 : idx + 1'b1;
            if (state == IDLE && resp_valid)
                corner_count <= {{bitSize{1'b0}}, push};
            else if (push && corner_count != (bitSize+1)'(PIX))
                corner_count <= corner_count + 1'b1;
            // Dropped corner, premature resp_last, or a pixel arriving while draining.
            if ((cand && !push) || (frame_end && !last_pix) || (state == DRAIN && resp_valid))
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{x: cur_x, y: cur_y, score: resp_value};
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_x     = out_valid ? head.x     : '0;
    assign out_y     = out_valid ? head.y     : '0;
    assign out_score = out_valid ? head.score : '0;
endmodule

// File: tb/tb_moravec_corner_collector.sv
// Scoreboard bench for moravec_corner_collector: expected corners are queued at drive time
// and compared at the output handshake; frame-level counters are checked after each frame.
module tb_moravec_corner_collector;
    localparam int N     = 8;
    localparam int RW    = 16;
    localparam int DEPTH = 16;
    localparam int THR   = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic [RW-1:0]   threshold;
    logic            resp_valid, resp_last, out_ready;
    logic [RW-1:0]   resp_value;
    logic            out_valid, frame_done, overflow;
    logic [2:0]      out_x, out_y;
    logic [RW-1:0]   out_score;
    logic [6:0]      corner_count;

    moravec_corner_collector #(.N(N), .respWidth(RW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .threshold(threshold), .resp_valid(resp_valid),
        .resp_value(resp_value), .resp_last(resp_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_score(out_score),
        .corner_count(corner_count), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int s; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, pops = 0;
    int m_idx = 0, m_cnt = 0;
    bit m_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) chk("unexpected_pop", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("head_x", 32'(out_x), e.x);
                chk("head_y", 32'(out_y), e.y);
                chk("head_score", 32'(out_score), e.s);
            end
        end
    end

    // Called at posedge+1; the pixel is accepted on the next rising edge.
    task automatic pix(input int v, input bit last);
        int  x, y;
        bit  cand;
        x = m_idx % N;
        y = m_idx / N;
        if (m_idx == 0) m_cnt = 0;
        cand = v > THR;
`ifdef MORAVEC_BORDER_SKIP_EN
        if (x == 0 || x == N-1 || y == 0 || y == N-1) cand = 0;
`endif
        if (cand) begin
            if (q.size() < DEPTH || (q.size() > 0 && out_ready)) begin
                q.push_back('{x, y, v});
                if (m_cnt < N*N) m_cnt++;
            end else m_ovf = 1;
        end
        if (last && m_idx != N*N-1) m_ovf = 1;
        if (last || m_idx == N*N-1) m_idx = 0;
        else m_idx++;
        resp_valid = 1; resp_value = RW'(v); resp_last = last;
        @(posedge clk); #1;
        resp_valid = 0; resp_last = 0; resp_value = '0;
    endtask

    task automatic run_frame(input int mode);
        for (int i = 0; i < N*N; i++) begin
            int v;
            case (mode)
                0: v = 50;
                1: v = (i == 27) ? 101 : (i == 36) ? 100 : 0;
                2: v = 200;
                default: v = (i == 9) ? 150 : 0;
            endcase
            pix(v, i == N*N-1);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(frame_done), 1);
        @(posedge clk); #1;
        chk({tag, "_pulse_len"}, 32'(frame_done), 0);
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        #2;
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_x"}, 32'(out_x), 0);
        chk({tag, "_y"}, 32'(out_y), 0);
        chk({tag, "_score"}, 32'(out_score), 0);
        chk({tag, "_cnt"}, 32'(corner_count), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        q.delete();
        m_idx = 0; m_cnt = 0; m_ovf = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

    initial begin
        rst = 1; threshold = RW'(THR); resp_valid = 0; resp_value = '0;
        resp_last = 0; out_ready = 1;
        @(posedge clk); #1;
        do_reset("rst0");

        // Everything below threshold.
        run_frame(0);
        chk("t1_done_next", 32'(frame_done), 1);
        wait_done("t1");
        chk("t1_cnt", 32'(corner_count), 0);
        chk("t1_ovf", 32'(overflow), 0);
        chk("t1_pops", pops, 0);

        // Strict compare: 101 passes, 100 does not.
        pops = 0;
        run_frame(1);
        wait_done("t2");
        chk("t2_cnt", 32'(corner_count), 1);
        chk("t2_pops", pops, 1);
        chk("t2_ovf", 32'(overflow), 0);

        // Every pixel strong, consumer always ready.
        run_frame(2);
        wait_done("t4");
`ifdef MORAVEC_BORDER_SKIP_EN
        chk("t4_cnt", 32'(corner_count), 36);
`else
        chk("t4_cnt", 32'(corner_count), 64);
`endif
        chk("t4_ovf", 32'(overflow), m_ovf);

        // Premature resp_last ends the frame and flags an error.
        pix(200, 0); pix(200, 0); pix(200, 0); pix(7, 1);
        wait_done("early");
        chk("early_ovf", 32'(overflow), 1);
        chk("early_cnt", 32'(corner_count), m_cnt);

        do_reset("rst1");

        // Fill the FIFO, then push and pop every cycle at full occupancy.
        out_ready = 0;
        for (int i = 0; i < N*N; i++) begin
            if (q.size() == DEPTH) out_ready = 1;
            pix(200, i == N*N-1);
        end
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_cnt", 32'(corner_count), m_cnt);
`ifndef MORAVEC_BORDER_SKIP_EN
        chk("t5_occ_model", q.size(), DEPTH);
`endif
        wait_done("t5");

        // Stalled consumer: FIFO fills and the rest of the frame is dropped.
        out_ready = 0;
        pops = 0;
        run_frame(2);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_cnt", 32'(corner_count), 16);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_stall_done", 32'(frame_done), 0);
        out_ready = 1;
        wait_done("t3");
        chk("t3_pops", pops, 16);

        // Reset mid-frame with 5 buffered corners.
        out_ready = 0;
        for (int i = 0; i < 20; i++) pix((i >= 9 && i <= 13) ? 200 : 0, 0);
        chk("t6_valid_pre", 32'(out_valid), 1);
        chk("t6_model_occ", q.size(), 5);
        do_reset("rst2");
        out_ready = 1;
        pops = 0;
        run_frame(3);
        wait_done("t6");
        chk("t6_cnt", 32'(corner_count), 1);
        chk("t6_pops", pops, 1);
        chk("t6_ovf", 32'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
